// File: rtl/bcrypt_core_rx_pkg.sv
// Shared bus definitions for the bcrypt arbiter->core link: control codes
// on ctrl[1:0] and memory region encodings on wr_region. The transmitter
// imports the same package so both ends agree on the encoding.
package bcrypt_core_rx_pkg;

  localparam logic [1:0] CTRL_IDLE       = 2'd0;
  localparam logic [1:0] CTRL_INIT_START = 2'd1;
  localparam logic [1:0] CTRL_DATA_START = 2'd2;
  localparam logic [1:0] CTRL_END        = 2'd3;

  localparam logic [1:0] REGION_P    = 2'd0;
  localparam logic [1:0] REGION_S    = 2'd1;
  localparam logic [1:0] REGION_DATA = 2'd2;

endpackage

// File: rtl/bcrypt_rx_deser.sv
// Byte-to-word deserializer. Bytes arrive LSB-first; the fourth accepted
// byte completes a word, which is presented on word/word_valid one cycle
// later. clr realigns the byte counter for the next packet.
module bcrypt_rx_deser (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  din,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [31:0] sr;

  // The byte currently being accepted is byte 3 of its word.
  assign last_byte = en && (byte_cnt == 2'd3);

  // Shift bytes in from the top so byte 0 ends up in bits [7:0].
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_cnt   <= 2'd0;
      sr         <= 32'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte;
      if (last_byte) word <= {din, sr[31:8]};
      if (en) sr <= {din, sr[31:8]};
      if (clr) byte_cnt <= 2'd0;
      else if (en) byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/bcrypt_core_rx.sv
// Receiver for the 10-bit arbiter->core bus. Decodes INIT and DATA packets,
// writes assembled words into the P/S/DATA regions and flags protocol
// errors (sticky until reset).
// Optional feature: define BCRYPT_RX_PKT_CNT_EN to add init_pkt_cnt and
// data_pkt_cnt, counting good packets (wrapping 16-bit counters).
module bcrypt_core_rx
  import bcrypt_core_rx_pkg::*;
#(
  parameter int INIT_P_WORDS = 30,
  parameter int S_WORDS      = 1024,
  parameter int DATA_WORDS   = 31
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  din,
  input  logic [1:0]  ctrl,
  output logic        wr_en,
  output logic [1:0]  wr_region,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        init_done,
  output logic        data_done,
  output logic        rx_busy,
  output logic [2:0]  error
`ifdef BCRYPT_RX_PKT_CNT_EN
  ,
  output logic [15:0] init_pkt_cnt,
  output logic [15:0] data_pkt_cnt
`endif
);

  localparam int INIT_WORDS = INIT_P_WORDS + S_WORDS;
  localparam int WCW        = $clog2(INIT_WORDS + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RX_INIT = 2'd1;
  localparam logic [1:0] ST_RX_DATA = 2'd2;

  logic [1:0]     state;
  logic [WCW-1:0] word_cnt;
  logic [WCW-1:0] words_max;
  logic           is_start, is_end, in_rx, full, last_word;
  logic           byte_en, deser_clr, last_byte;

  assign is_start  = (ctrl == CTRL_INIT_START) || (ctrl == CTRL_DATA_START);
  assign is_end    = (ctrl == CTRL_END);
  assign in_rx     = (state != ST_IDLE);
  assign rx_busy   = in_rx;

  // Word limit of the packet in progress.
  always_comb begin
    words_max = WCW'(DATA_WORDS);
    if (state == ST_RX_INIT) words_max = WCW'(INIT_WORDS);
  end

  // full: every word already received, so any further payload is an overrun.
  assign full      = (word_cnt == words_max);
  assign last_word = (word_cnt == words_max - WCW'(1));

  // Overrun bytes are never fed to the deserializer; any exit from the
  // receive states (or a restart) realigns it to byte 0.
  assign byte_en   = in_rx && !is_start && !full;
  assign deser_clr = !in_rx || is_start || is_end || full;

  bcrypt_rx_deser u_deser (
    .CLK        (CLK),
    .RST        (RST),
    .en         (byte_en),
    .clr        (deser_clr),
    .din        (din),
    .last_byte  (last_byte),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  // Packet FSM, word addressing, completion pulses and sticky errors.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      wr_region <= 2'd0;
      wr_addr   <= 10'd0;
      init_done <= 1'b0;
      data_done <= 1'b0;
      error     <= 3'd0;
    end else begin
      init_done <= 1'b0;
      data_done <= 1'b0;

      // Address travels alongside the word so both appear with wr_en.
      if (last_byte) begin
        if (state == ST_RX_INIT && word_cnt >= WCW'(INIT_P_WORDS)) begin
          wr_region <= REGION_S;
          wr_addr   <= 10'(word_cnt - WCW'(INIT_P_WORDS));
        end else if (state == ST_RX_INIT) begin
          wr_region <= REGION_P;
          wr_addr   <= 10'(word_cnt);
        end else begin
          wr_region <= REGION_DATA;
          wr_addr   <= 10'(word_cnt);
        end
      end

      if (is_start) begin
        // A START always wins: it aborts anything in flight and opens a new packet.
        if (in_rx) error[2] <= 1'b1;
        state    <= (ctrl == CTRL_INIT_START) ? ST_RX_INIT : ST_RX_DATA;
        word_cnt <= '0;
      end else if (in_rx) begin
        if (full) begin
          error[1] <= 1'b1;
          state    <= ST_IDLE;
        end else begin
          if (last_byte) word_cnt <= word_cnt + WCW'(1);
          if (is_end) begin
            state <= ST_IDLE;
            if (!last_byte) begin
              error[1] <= 1'b1;
            end else if (last_word) begin
              if (state == ST_RX_INIT) init_done <= 1'b1;
              else data_done <= 1'b1;
            end else begin
              error[0] <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef BCRYPT_RX_PKT_CNT_EN
  // Good-packet counters, advancing with each done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_pkt_cnt <= 16'd0;
      data_pkt_cnt <= 16'd0;
    end else begin
      if (init_done) init_pkt_cnt <= init_pkt_cnt + 16'd1;
      if (data_done) data_pkt_cnt <= data_pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcrypt_core_rx.sv
// Self-checking bench for bcrypt_core_rx. Packets are described at packet
// level (kind, termination style, word count); the expected write stream,
// done pulses and sticky error bits are derived from that description.
module tb_bcrypt_core_rx;
  import bcrypt_core_rx_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  din = 8'd0;
  logic [1:0]  ctrl = 2'd0;
  logic        wr_en, init_done, data_done, rx_busy;
  logic [1:0]  wr_region;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  error;
`ifdef BCRYPT_RX_PKT_CNT_EN
  logic [15:0] init_pkt_cnt, data_pkt_cnt;
`endif

  bcrypt_core_rx dut (
    .CLK(CLK), .RST(RST), .din(din), .ctrl(ctrl),
    .wr_en(wr_en), .wr_region(wr_region), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done), .data_done(data_done), .rx_busy(rx_busy), .error(error)
`ifdef BCRYPT_RX_PKT_CNT_EN
    , .init_pkt_cnt(init_pkt_cnt), .data_pkt_cnt(data_pkt_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  region;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        idone;
    logic        ddone;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t expq[$];
  exp_t e;
  logic [2:0]  exp_err = 3'd0;
  int exp_idone = 0, exp_ddone = 0;   // pulses expected over the whole run
  int n_idone = 0, n_ddone = 0;       // pulses observed
  int cnt_i = 0, cnt_d = 0;           // good packets since last reset
  logic [31:0] mem_p [0:29];
  logic [31:0] mem_s [0:1023];
  logic [31:0] mem_d [0:30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Every cycle: a write must match the head of the expected stream, and
  // done pulses may only accompany the matching final write.
  always @(negedge CLK) begin
    if (!RST) begin
      if (wr_en) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got region %0d addr %0d data %0h, required no write",
                   wr_region, wr_addr, wr_data);
        end else begin
          e = expq.pop_front();
          chk("wr_region", {30'd0, wr_region}, {30'd0, e.region});
          chk("wr_addr", {22'd0, wr_addr}, {22'd0, e.addr});
          chk("wr_data", wr_data, e.data);
          chk("init_done_with_write", {31'd0, init_done}, {31'd0, e.idone});
          chk("data_done_with_write", {31'd0, data_done}, {31'd0, e.ddone});
        end
        if (wr_region == REGION_P && wr_addr < 10'd30) mem_p[wr_addr] = wr_data;
        if (wr_region == REGION_S) mem_s[wr_addr] = wr_data;
        if (wr_region == REGION_DATA && wr_addr < 10'd31) mem_d[wr_addr] = wr_data;
      end else begin
        chk("done_without_write", {30'd0, init_done, data_done}, 32'd0);
      end
      if (init_done) n_idone++;
      if (data_done) n_ddone++;
    end
  end

  // One bus cycle: drive, let the DUT sample, return 1 time unit after the edge.
  task automatic put(input logic [1:0] c, input logic [7:0] d);
    ctrl = c;
    din  = d;
    @(posedge CLK);
    #1;
  endtask

  // Expected destination of word k follows directly from the packet layout.
  function automatic void expect_word(input bit is_init, input int k, input logic [31:0] w,
                                      input bit idone, input bit ddone);
    exp_t x;
    if (!is_init) begin
      x.region = REGION_DATA; x.addr = 10'(k);
    end else if (k < 30) begin
      x.region = REGION_P; x.addr = 10'(k);
    end else begin
      x.region = REGION_S; x.addr = 10'(k - 30);
    end
    x.data = w; x.idone = idone; x.ddone = ddone;
    expq.push_back(x);
  endfunction

  // mode: 0 good, 1 END on byte 3 but short, 2 END mid-word after n words
  // (tail bytes 1..3), 3 overrun byte after a full packet, 4 abandoned after
  // n words + tail bytes (next START aborts it).
  // pat: 0 random words, 1 word k = k, 2 bytes numbered 4k..4k+3.
  task automatic send_pkt(input bit is_init, input int mode, input int n,
                          input int tail, input int pat);
    int maxw, nw;
    logic [31:0] w;
    logic [7:0]  lb;
    bit end_here;
    maxw = is_init ? 1054 : 31;
    nw   = (mode == 0 || mode == 3) ? maxw : n;
    put(is_init ? CTRL_INIT_START : CTRL_DATA_START, 8'($urandom));
    chk("rx_busy_after_start", {31'd0, rx_busy}, 32'd1);
    for (int k = 0; k < nw; k++) begin
      if (pat == 1) w = 32'(k);
      else if (pat == 2) w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      else w = $urandom;
      end_here = (k == nw - 1) && (mode == 0 || mode == 1);
      expect_word(is_init, k, w, end_here && mode == 0 && is_init,
                  end_here && mode == 0 && !is_init);
      for (int b = 0; b < 4; b++)
        put((end_here && b == 3) ? CTRL_END : CTRL_IDLE, w[8*b +: 8]);
    end
    case (mode)
      0: begin
        if (is_init) begin exp_idone++; cnt_i++; end
        else begin exp_ddone++; cnt_d++; end
      end
      1: exp_err[0] = 1'b1;
      2: begin
        for (int b = 0; b < tail; b++) begin
          lb = 8'($urandom);
          put((b == tail - 1) ? CTRL_END : CTRL_IDLE, lb);
        end
        exp_err[1] = 1'b1;
      end
      3: begin
        put($urandom_range(0, 1) ? CTRL_END : CTRL_IDLE, 8'($urandom));
        exp_err[1] = 1'b1;
      end
      default: begin
        for (int b = 0; b < tail; b++) put(CTRL_IDLE, 8'($urandom));
        exp_err[2] = 1'b1;
      end
    endcase
    if (mode != 4) begin
      // Idle gap; END while idle must be ignored.
      for (int i = 0; i < 3; i++)
        put($urandom_range(0, 3) == 0 ? CTRL_END : CTRL_IDLE, 8'($urandom));
      chk("error_after_pkt", {29'd0, error}, {29'd0, exp_err});
      chk("rx_busy_idle", {31'd0, rx_busy}, 32'd0);
      chk("writes_drained", expq.size(), 32'd0);
      chk("init_done_count", n_idone, exp_idone);
      chk("data_done_count", n_ddone, exp_ddone);
`ifdef BCRYPT_RX_PKT_CNT_EN
      chk("init_pkt_cnt", {16'd0, init_pkt_cnt}, 32'(cnt_i % 65536));
      chk("data_pkt_cnt", {16'd0, data_pkt_cnt}, 32'(cnt_d % 65536));
`endif
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, mode, n, tail;
    #1;
    chk("reset_outputs", {wr_en, init_done, data_done, rx_busy, error, wr_region, 22'd0},
        32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_wr_addr", {22'd0, wr_addr}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;

    // 1: counting-byte DATA packet
    send_pkt(1'b0, 0, 0, 0, 2);
    chk("t1_word0", mem_d[0], 32'h03020100);
    chk("t1_word30", mem_d[30], 32'h7B7A7978);
    chk("t1_error", {29'd0, error}, 32'd0);

    // 2: full INIT packet, word k = k
    send_pkt(1'b1, 0, 0, 0, 1);
    chk("t2_p0", mem_p[0], 32'd0);
    chk("t2_p29", mem_p[29], 32'd29);
    chk("t2_s0", mem_s[0], 32'd30);
    chk("t2_s1023", mem_s[1023], 32'd1053);
    chk("t2_init_done_once", n_idone, 32'd1);

    // 3: END on byte 1 of word 5, then a good DATA packet
    send_pkt(1'b0, 2, 5, 2, 0);
    send_pkt(1'b0, 0, 0, 0, 0);
    chk("t3_error", {29'd0, error}, 32'b010);

    // 4: INIT aborted after 10 words by a DATA START
    send_pkt(1'b1, 4, 10, 0, 0);
    send_pkt(1'b0, 0, 0, 0, 0);
    chk("t4_error", {29'd0, error}, 32'b110);
    chk("t4_no_init_done", n_idone, 32'd1);

    // 5: reset at DATA word 12 byte 2
    put(CTRL_DATA_START, 8'd0);
    for (int k = 0; k < 12; k++) begin
      expect_word(1'b0, k, 32'h5A000000 | 32'(k), 1'b0, 1'b0);
      for (int b = 0; b < 4; b++) put(CTRL_IDLE, (k == 0 && b == 3) ? 8'h5A :
                                                 (b == 3) ? 8'h5A : (b == 0) ? 8'(k) : 8'd0);
    end
    put(CTRL_IDLE, 8'h11);
    put(CTRL_IDLE, 8'h22);
    RST = 1'b1;
    #1;
    chk("t5_rst_outputs", {wr_en, init_done, data_done, rx_busy, error}, 32'd0);
    chk("t5_rst_wr_data", wr_data, 32'd0);
    chk("t5_writes_before_rst", expq.size(), 32'd0);
    exp_err = 3'd0; cnt_i = 0; cnt_d = 0;
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    send_pkt(1'b0, 0, 0, 0, 0);
    chk("t5_error_clear", {29'd0, error}, 32'd0);

    // 6: reach 3 good DATA + 1 good INIT since reset
    send_pkt(1'b0, 0, 0, 0, 0);
    send_pkt(1'b1, 0, 0, 0, 0);
    send_pkt(1'b0, 0, 0, 0, 0);
`ifdef BCRYPT_RX_PKT_CNT_EN
    chk("t6_data_pkt_cnt", {16'd0, data_pkt_cnt}, 32'd3);
    chk("t6_init_pkt_cnt", {16'd0, init_pkt_cnt}, 32'd1);
`endif

    // Randomized packet mix; INIT packets are kept short to bound runtime.
    for (int i = 0; i < 40; i++) begin
      kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
      if (kind == 1) begin
        mode = $urandom_range(0, 2);
        mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
        n = $urandom_range(1, 40);
      end else begin
        mode = $urandom_range(0, 4);
        n = $urandom_range(1, 30);
      end
      tail = (mode == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      send_pkt(kind[0], mode, n, tail, 0);
    end
    send_pkt(1'b0, 0, 0, 0, 0);
    chk("final_queue_empty", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
